// File: rtl/markov_song_generator_pkg.sv
// Shared widths, state encoding and field-extract helpers for the Markov song generator.
// Entry layout (LSB first): count, event 0 (oldest) .. event SEQUENCE_LEN-1 (successor); note in each event's MSBs.
package markov_song_generator_pkg;

  localparam int NOTE_BIT_LEN     = 8;
  localparam int DELAY_BIT_LEN    = 8;
  localparam int SEQUENCE_LEN     = 2;
  localparam int SEQ_CNT_BIT_LEN  = 8;
  localparam int MARKOV_CHAIN_LEN = 16;
  localparam int SONG_OUT_LEN     = 32;
  localparam int LFSR_W           = 16;

  localparam int EV_W       = NOTE_BIT_LEN + DELAY_BIT_LEN;
  localparam int ENTRY_W    = SEQUENCE_LEN * EV_W + SEQ_CNT_BIT_LEN;
  localparam int CTX_W      = (SEQUENCE_LEN - 1) * EV_W;
  localparam int IDX_W      = $clog2(MARKOV_CHAIN_LEN);
  localparam int TOT_W      = SEQ_CNT_BIT_LEN + IDX_W;
  localparam int EMIT_CNT_W = $clog2(SONG_OUT_LEN + 1);

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10 feed back
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'hACE1;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(MARKOV_CHAIN_LEN - 1);
  localparam logic [EMIT_CNT_W-1:0] LAST_EMIT = EMIT_CNT_W'(SONG_OUT_LEN - 1);

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [EV_W-1:0]    event_t;
  typedef logic [CTX_W-1:0]   ctx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESEED,
    ST_SUM,
    ST_PICK,
    ST_SELECT,
    ST_EMIT,
    ST_FIN
  } state_t;

  function automatic logic [SEQ_CNT_BIT_LEN-1:0] entry_count(input entry_t e);
    return e[SEQ_CNT_BIT_LEN-1:0];
  endfunction

  function automatic event_t entry_event(input entry_t e, input int k);
    return e[SEQ_CNT_BIT_LEN + k*EV_W +: EV_W];
  endfunction

  // Context-shaped view of events 0..SEQUENCE_LEN-2 (what the entry is conditioned on)
  function automatic ctx_t entry_head(input entry_t e);
    return e[SEQ_CNT_BIT_LEN +: CTX_W];
  endfunction

  // Events 1..SEQUENCE_LEN-1: the context left behind after emitting this entry's successor
  function automatic ctx_t entry_tail(input entry_t e);
    return e[SEQ_CNT_BIT_LEN + EV_W +: CTX_W];
  endfunction

  function automatic ctx_t ctx_shift(input ctx_t c, input event_t s);
    return CTX_W'({s, c} >> EV_W);
  endfunction

endpackage

// File: rtl/markov_lfsr.sv
// Fibonacci left-shifting LFSR with seed load; a zero seed is replaced so the register never locks up.
module markov_lfsr
  import markov_song_generator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      value_q <= {value_q[LFSR_W-2:0], ^(value_q & LFSR_TAPS)};
    end
  end

  assign value = value_q;

endmodule

// File: rtl/markov_song_generator.sv
// Walks a packed weighted Markov table and emits SONG_OUT_LEN (note, delay) events per run.
// Each event: SUM matching counts, PICK a random threshold, SELECT the weighted winner, EMIT it.
module markov_song_generator
  import markov_song_generator_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [LFSR_W-1:0]                     seed,
  input  logic [MARKOV_CHAIN_LEN*ENTRY_W-1:0]   markov,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NOTE_BIT_LEN-1:0]               out_note,
  output logic [DELAY_BIT_LEN-1:0]              out_delay,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error
);

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          scan_q, scan_d;
  logic [TOT_W-1:0]          total_q, total_d;
  logic [TOT_W-1:0]          cum_q, cum_d;
  logic [TOT_W-1:0]          r_q, r_d;
  ctx_t                      ctx_q, ctx_d;
  event_t                    succ_q, succ_d;
  logic [EMIT_CNT_W-1:0]     emit_q, emit_d;
  logic                      error_q, error_d;

  logic                      lfsr_load, lfsr_step;
  logic [LFSR_W-1:0]         lfsr;

  entry_t                    ent_arr [MARKOV_CHAIN_LEN];
  logic [IDX_W-1:0]          idx;
  entry_t                    entry;
  logic [SEQ_CNT_BIT_LEN-1:0] cnt;
  logic                      ent_valid, ent_match;
  logic [TOT_W-1:0]          total_acc, cum_after, r_pick;
  logic [LFSR_W+TOT_W-1:0]   product;

  markov_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed),
    .value (lfsr)
  );

  for (genvar g = 0; g < MARKOV_CHAIN_LEN; g++) begin : g_unpack
    assign ent_arr[g] = markov[g*ENTRY_W +: ENTRY_W];
  end

  // RESEED scans from a random origin; SUM and SELECT always scan from entry 0
  assign idx       = (state == ST_RESEED) ? lfsr[IDX_W-1:0] + scan_q : scan_q;
  assign entry     = ent_arr[idx];
  assign cnt       = entry_count(entry);
  assign ent_valid = (cnt != '0);
  assign ent_match = ent_valid && (entry_head(entry) == ctx_q);
  assign total_acc = total_q + (ent_match ? TOT_W'(cnt) : '0);
  assign cum_after = cum_q + TOT_W'(cnt);
  // r = floor(lfsr * total / 2^LFSR_W) lands in [0, total)
  assign product   = (LFSR_W+TOT_W)'(lfsr) * (LFSR_W+TOT_W)'(total_q);
  assign r_pick    = TOT_W'(product >> LFSR_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      scan_q  <= '0;
      total_q <= '0;
      cum_q   <= '0;
      r_q     <= '0;
      ctx_q   <= '0;
      succ_q  <= '0;
      emit_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      scan_q  <= scan_d;
      total_q <= total_d;
      cum_q   <= cum_d;
      r_q     <= r_d;
      ctx_q   <= ctx_d;
      succ_q  <= succ_d;
      emit_q  <= emit_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_nxt = state;
    scan_d    = scan_q;
    total_d   = total_q;
    cum_d     = cum_q;
    r_d       = r_q;
    ctx_d     = ctx_q;
    succ_d    = succ_q;
    emit_d    = emit_q;
    error_d   = error_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          emit_d    = '0;
          error_d   = 1'b0;
          scan_d    = '0;
          state_nxt = ST_RESEED;
        end
      end

      ST_RESEED: begin
        if (ent_valid) begin
          succ_d    = entry_event(entry, SEQUENCE_LEN - 1);
          ctx_d     = entry_tail(entry);
          state_nxt = ST_EMIT;
        end else if (scan_q == LAST_IDX) begin
          error_d   = 1'b1;
          state_nxt = ST_FIN;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      ST_SUM: begin
        total_d = total_acc;
        if (scan_q == LAST_IDX) begin
          scan_d    = '0;
          cum_d     = '0;
          state_nxt = (total_acc == '0) ? ST_RESEED : ST_PICK;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      ST_PICK: begin
        r_d       = r_pick;
        lfsr_step = 1'b1;
        scan_d    = '0;
        cum_d     = '0;
        state_nxt = ST_SELECT;
      end

      ST_SELECT: begin
        if (ent_match) begin
          cum_d = cum_after;
        end
        if (ent_match && (cum_after > r_q)) begin
          succ_d    = entry_event(entry, SEQUENCE_LEN - 1);
          ctx_d     = ctx_shift(ctx_q, entry_event(entry, SEQUENCE_LEN - 1));
          state_nxt = ST_EMIT;
        end else if (scan_q == LAST_IDX) begin
          // Only reachable if the table changed under us; recover via a fresh reseed
          scan_d    = '0;
          state_nxt = ST_RESEED;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end

      // Handshake: an event transfers on a rising edge where out_valid && out_ready;
      // out_valid never drops and the payload never changes until that edge.
      ST_EMIT: begin
        if (out_ready) begin
          lfsr_step = 1'b1;
          emit_d    = emit_q + 1'b1;
          scan_d    = '0;
          total_d   = '0;
          state_nxt = (emit_q == LAST_EMIT) ? ST_FIN : ST_SUM;
        end
      end

      ST_FIN: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_valid = (state == ST_EMIT);
  assign out_note  = out_valid ? succ_q[EV_W-1 -: NOTE_BIT_LEN] : '0;
  assign out_delay = out_valid ? succ_q[DELAY_BIT_LEN-1:0] : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign error     = error_q;

endmodule

// File: tb/tb_markov_song_generator.sv
// Scoreboard bench: a behavioural song model fills exp_q at each start; a negedge monitor pops on handshakes.
module tb_markov_song_generator;
  import markov_song_generator_pkg::*;

  localparam int N = MARKOV_CHAIN_LEN;
  localparam logic [EV_W-1:0] EV_A = 16'h3C10;
  localparam logic [EV_W-1:0] EV_B = 16'h4020;
  localparam logic [EV_W-1:0] EV_C = 16'h4308;

  logic                        clk = 1'b0;
  logic                        reset, start, out_ready;
  logic [LFSR_W-1:0]           seed;
  logic [N*ENTRY_W-1:0]        markov;
  logic                        out_valid, busy, done, error;
  logic [NOTE_BIT_LEN-1:0]     out_note;
  logic [DELAY_BIT_LEN-1:0]    out_delay;

  logic [EV_W-1:0]             exp_q[$];
  logic [EV_W-1:0]             run_log[$];
  logic [EV_W-1:0]             t_ctx [N];
  logic [EV_W-1:0]             t_nxt [N];
  logic [SEQ_CNT_BIT_LEN-1:0]  t_cnt [N];

  int n_vec, n_err;
  int hs_count, done_count, valid_cycles;
  int cyc, mism, n_after_a, c_cnt, bad, hs0, d0, c;
  logic rand_ready, stall_force;
  logic stall_prev;
  logic [EV_W-1:0] stall_val;

  markov_song_generator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .markov    (markov),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_note  (out_note),
    .out_delay (out_delay),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      t_ctx[i] = '0; t_nxt[i] = '0; t_cnt[i] = '0;
    end
  endtask

  task automatic set_entry(input int i, input logic [EV_W-1:0] cx, input logic [EV_W-1:0] nx,
                           input logic [SEQ_CNT_BIT_LEN-1:0] k);
    t_ctx[i] = cx; t_nxt[i] = nx; t_cnt[i] = k;
  endtask

  task automatic pack_table();
    for (int i = 0; i < N; i++) markov[i*ENTRY_W +: ENTRY_W] = {t_nxt[i], t_ctx[i], t_cnt[i]};
  endtask

  // Reference song: weighted draw over matching entries, reseed on dead end, LFSR stepped per pick and per event
  task automatic model_run(input logic [15:0] s, output logic err);
    logic [15:0] lf;
    logic [EV_W-1:0] ctx;
    bit have;
    int pick, k;
    longint total, r, cum;
    lf = (s == 16'h0) ? 16'hACE1 : s;
    ctx = '0; have = 0; err = 1'b0;
    for (int n = 0; n < SONG_OUT_LEN; n++) begin
      pick = -1;
      if (have) begin
        total = 0;
        for (int i = 0; i < N; i++) if (t_cnt[i] != 0 && t_ctx[i] == ctx) total += t_cnt[i];
        if (total > 0) begin
          r = (longint'(lf) * total) >> 16;
          lf = lfsr_next(lf);
          cum = 0;
          for (int i = 0; i < N; i++) begin
            if (pick < 0 && t_cnt[i] != 0 && t_ctx[i] == ctx) begin
              cum += t_cnt[i];
              if (cum > r) pick = i;
            end
          end
        end
      end
      if (pick < 0) begin
        for (int j = 0; j < N; j++) begin
          k = (int'(lf) + j) % N;
          if (pick < 0 && t_cnt[k] != 0) pick = k;
        end
      end
      if (pick < 0) begin
        err = 1'b1;
        return;
      end
      exp_q.push_back(t_nxt[pick]);
      ctx = t_nxt[pick];
      have = 1;
      lf = lfsr_next(lf);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_song(input logic [15:0] s, input int stall_at, input int poke_at, output int cycles);
    logic err_exp;
    bit got_done;
    exp_q.delete();
    run_log.delete();
    model_run(s, err_exp);
    valid_cycles = 0;
    pack_table();
    @(posedge clk); #1 start = 1'b1; seed = s;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared_on_start", error, 0);
    cycles = 0; got_done = 0;
    while (cycles < 6000 && !got_done) begin
      @(negedge clk);
      cycles++;
      if (cycles == stall_at) stall_force = 1'b1;
      if (cycles == stall_at + 10) stall_force = 1'b0;
      if (cycles == poke_at) begin start = 1'b1; seed = ~s; end
      else if (cycles == poke_at + 1) begin start = 1'b0; seed = s; end
      if (done) got_done = 1;
    end
    stall_force = 1'b0;
    start = 1'b0;
    if (!got_done) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done after %0d cycles, required done", cycles);
    end else begin
      check("error_flag", error, err_exp);
      check("busy_in_fin", busy, 1);
      check("events_outstanding", exp_q.size(), 0);
      check("event_total", run_log.size(), err_exp ? 0 : SONG_OUT_LEN);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_fin", busy, 0);
      check("error_held", error, err_exp);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = stall_force ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EV_W-1:0] got;
    stall_prev = 1'b0;
    stall_val = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        got = {out_note, out_delay};
        if (done) done_count++;
        if (out_valid) valid_cycles++;
        if (stall_prev) begin
          check("valid_held_under_stall", out_valid, 1);
          if (out_valid) check("payload_held_under_stall", got, stall_val);
        end
        if (out_valid && out_ready) begin
          hs_count++;
          run_log.push_back(got);
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL extra_event: got %0h, required no event", got);
          end else begin
            check("event", got, exp_q.pop_front());
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_val = got;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; hs_count = 0; done_count = 0; valid_cycles = 0;
    reset = 1'b1; start = 1'b0; seed = '0; markov = '0;
    rand_ready = 1'b0; stall_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {out_valid, busy, done, error, out_note, out_delay}, 0);
    reset = 1'b0;
    @(posedge clk); #1 check("idle_outputs", {out_valid, busy, done, error, out_note, out_delay}, 0);

    // Deterministic two-entry chain
    clear_table();
    set_entry(0, EV_A, EV_B, 3);
    set_entry(1, EV_B, EV_A, 5);
    run_song(16'h5A30, -1, -1, cyc);
    mism = 0;
    for (int i = 0; i < run_log.size(); i++) if (run_log[i] !== ((i % 2 == 0) ? EV_B : EV_A)) mism++;
    check("alternating_pattern", mism, 0);

    // Zero seed is substituted (0xACE1 starts the scan at entry 1)
    run_song(16'h0000, -1, -1, cyc);
    check("zero_seed_first_event", (run_log.size() > 0) ? run_log[0] : 16'h0, EV_A);

    // Weighted split after A
    clear_table();
    set_entry(2, EV_A, EV_B, 1);
    set_entry(5, EV_B, EV_A, 1);
    set_entry(9, EV_A, EV_C, 255);
    set_entry(12, EV_C, EV_A, 1);
    n_after_a = 0; c_cnt = 0; bad = 0;
    for (int run = 0; run < 16; run++) begin
      run_song(16'($urandom), -1, -1, cyc);
      for (int i = 1; i < run_log.size(); i++) begin
        if (run_log[i-1] == EV_A) begin
          n_after_a++;
          if (run_log[i] == EV_C) c_cnt++;
          else if (run_log[i] != EV_B) bad++;
        end
      end
    end
    check("after_a_is_b_or_c", bad, 0);
    check("c_weight_ge_240_of_256", (c_cnt * 256 >= 240 * n_after_a) && (n_after_a > 0), 1);

    // Dead end: every event comes from RESEED; also a start pulse mid-run must be ignored
    clear_table();
    set_entry($urandom_range(0, N-1), EV_A, EV_B, 1);
    rand_ready = 1'b1;
    run_song(16'($urandom), -1, 100, cyc);
    mism = 0;
    for (int i = 0; i < run_log.size(); i++) if (run_log[i] !== EV_B) mism++;
    check("dead_end_all_b", mism, 0);

    // Backpressure with random ready plus a 10-cycle hold
    clear_table();
    set_entry(0, EV_A, EV_B, 3);
    set_entry(1, EV_B, EV_A, 5);
    set_entry(7, EV_B, EV_C, 2);
    set_entry(11, EV_C, EV_B, 4);
    run_song(16'($urandom), 300, -1, cyc);
    rand_ready = 1'b0;

    // All-zero table
    clear_table();
    run_song(16'($urandom), -1, -1, cyc);
    check("zero_table_done_latency_ok", cyc <= N + 2, 1);
    check("zero_table_no_valid", valid_cycles, 0);

    // Reset during SELECT of the second event, then rerun the same seed
    clear_table();
    set_entry(0, EV_A, EV_B, 3);
    set_entry(1, EV_B, EV_A, 5);
    exp_q.delete();
    run_log.delete();
    model_run(16'h5A30, mism[0]);
    pack_table();
    hs0 = hs_count;
    d0 = done_count;
    @(posedge clk); #1 start = 1'b1; seed = 16'h5A30;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (hs_count == hs0 && c < 100) begin @(negedge clk); c++; end
    check("first_handshake_seen", hs_count, hs0 + 1);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1 reset = 1'b1;
    #1 check("abort_outputs_async", {out_valid, busy, done, error, out_note, out_delay}, 0);
    @(posedge clk); #1 check("abort_outputs_next_edge", {out_valid, busy, done, error, out_note, out_delay}, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("no_done_on_abort", done_count, d0);
    check("idle_after_abort", busy, 0);
    run_song(16'h5A30, -1, -1, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
